// File: rtl/ysyx_23060136_ifu_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_ifu_fetch_pkg
//   Shared definitions for the instruction fetch unit and the stages that
//   consume its IFU->IDU register (decode sees the same NOP and reset PC).
//   Contents:
//     IFU_BITS_W / IFU_INST_W : default PC and instruction widths
//     IFU_PC_RST              : architectural PC after reset
//     IFU_NOP                 : bubble instruction (addi x0,x0,0)
//     ifu_state_e             : fetch FSM states
// ----------------------------------------------------------------------------
package ysyx_23060136_ifu_fetch_pkg;

  localparam int          IFU_BITS_W = 32;
  localparam int          IFU_INST_W = 32;
  localparam logic [31:0] IFU_PC_RST = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP    = 32'h0000_0013;

  // S_IDLE : one cycle after reset, loads the first request address
  // S_AR   : read request presented, waiting for arready
  // S_R    : waiting for read data
  // S_HOLD : instruction presented to decode until it is accepted
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060136_ifu_pc_gen.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_ifu_pc_gen
//   Combinational next-value logic for the architectural fetch PC and the
//   read-request address register.
//   Ports:
//     state        in  current fetch FSM state
//     drop         in  the outstanding response belongs to a flushed request
//     flush        in  branch redirect this cycle
//     target       in  redirect PC (low two bits ignored)
//     stall        in  decode cannot take the held instruction
//     rvalid       in  read data arriving this cycle
//     pc_cur       in  current architectural PC
//     ar_addr_cur  in  current request address
//     pc_next      out next architectural PC
//     ar_addr_next out next request address
// ----------------------------------------------------------------------------
module ysyx_23060136_ifu_pc_gen
  import ysyx_23060136_ifu_fetch_pkg::*;
#(
  parameter int BITS_W = IFU_BITS_W
) (
  input  ifu_state_e        state,
  input  logic              drop,
  input  logic              flush,
  input  logic [BITS_W-1:0] target,
  input  logic              stall,
  input  logic              rvalid,
  input  logic [BITS_W-1:0] pc_cur,
  input  logic [BITS_W-1:0] ar_addr_cur,
  output logic [BITS_W-1:0] pc_next,
  output logic [BITS_W-1:0] ar_addr_next
);

  logic [BITS_W-1:0] target_aligned;
  logic [BITS_W-1:0] pc_inc;

  // Instructions are word aligned; wrap-around at 2^BITS_W is intended.
  assign target_aligned = target & ~BITS_W'(3);
  assign pc_inc         = pc_cur + BITS_W'(4);

  always_comb begin
    pc_next      = pc_cur;
    ar_addr_next = ar_addr_cur;
    // A redirect always wins over stall and normal advance.
    if (flush) begin
      pc_next = target_aligned;
    end
    case (state)
      S_IDLE: ar_addr_next = flush ? target_aligned : pc_cur;
      // S_AR keeps the presented address stable until it is accepted, even
      // when redirected; the stale response is dropped later.
      S_AR:   ar_addr_next = ar_addr_cur;
      S_R: begin
        // A discarded response re-issues at the newest PC.
        if (rvalid && (drop || flush)) begin
          ar_addr_next = flush ? target_aligned : pc_cur;
        end
      end
      S_HOLD: begin
        if (flush) begin
          ar_addr_next = target_aligned;
        end else if (!stall) begin
          pc_next      = pc_inc;
          ar_addr_next = pc_inc;
        end
      end
      default: ar_addr_next = ar_addr_cur;
    endcase
  end

endmodule

// File: rtl/ysyx_23060136_ifu_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_23060136_ifu_fetch
//   Instruction fetch stage. Owns the architectural fetch PC and keeps a single
//   read outstanding on an AR/R valid-ready interface. The fetched instruction
//   is held for decode until accepted; branch redirects cancel in-flight work.
//   Ports:
//     clk, rst (async, active-low)
//     BRANCH_flushIF / BRANCH_target : redirect from the branch unit
//     FORWARD_stallIF                : decode cannot accept the held instruction
//     IFU_o_pc / IFU_o_inst / IFU_o_commit : IFU->IDU register inputs
//     ifu_arvalid / ifu_araddr / ifu_arready : read request channel
//     ifu_rvalid / ifu_rdata / ifu_rready    : read data channel
//   Optional build macro YSYX_23060136_IFU_PERF_EN adds:
//     IFU_o_fetch_cnt : instructions accepted by decode (wraps)
//     IFU_o_wait_cnt  : cycles spent in S_AR or S_R (wraps)
// ----------------------------------------------------------------------------
module ysyx_23060136_ifu_fetch
  import ysyx_23060136_ifu_fetch_pkg::*;
#(
  parameter int                BITS_W = IFU_BITS_W,
  parameter int                INST_W = IFU_INST_W,
  parameter logic [BITS_W-1:0] PC_RST = BITS_W'(IFU_PC_RST),
  parameter logic [INST_W-1:0] NOP    = INST_W'(IFU_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BRANCH_flushIF,
  input  logic [BITS_W-1:0] BRANCH_target,
  input  logic              FORWARD_stallIF,
  output logic [BITS_W-1:0] IFU_o_pc,
  output logic [INST_W-1:0] IFU_o_inst,
  output logic              IFU_o_commit,
  output logic              ifu_arvalid,
  output logic [BITS_W-1:0] ifu_araddr,
  input  logic              ifu_arready,
  input  logic              ifu_rvalid,
  input  logic [INST_W-1:0] ifu_rdata,
  output logic              ifu_rready
`ifdef YSYX_23060136_IFU_PERF_EN
  ,
  output logic [63:0]       IFU_o_fetch_cnt,
  output logic [63:0]       IFU_o_wait_cnt
`endif
);

  ifu_state_e        state_q;
  logic [BITS_W-1:0] pc_q;
  logic [BITS_W-1:0] ar_addr_q;
  logic [INST_W-1:0] inst_q;
  logic              drop_q;   // response in flight belongs to a flushed request
  logic [BITS_W-1:0] pc_next;
  logic [BITS_W-1:0] ar_addr_next;
  logic              hold_valid;

  ysyx_23060136_ifu_pc_gen #(
    .BITS_W (BITS_W)
  ) u_pc_gen (
    .state        (state_q),
    .drop         (drop_q),
    .flush        (BRANCH_flushIF),
    .target       (BRANCH_target),
    .stall        (FORWARD_stallIF),
    .rvalid       (ifu_rvalid),
    .pc_cur       (pc_q),
    .ar_addr_cur  (ar_addr_q),
    .pc_next      (pc_next),
    .ar_addr_next (ar_addr_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      ar_addr_q <= PC_RST;
      inst_q    <= NOP;
      drop_q    <= 1'b0;
    end else begin
      pc_q      <= pc_next;
      ar_addr_q <= ar_addr_next;
      case (state_q)
        S_IDLE: state_q <= S_AR;
        S_AR: begin
          // The request cannot be withdrawn; remember to discard its data.
          if (BRANCH_flushIF) begin
            drop_q <= 1'b1;
          end
          if (ifu_arready) begin
            state_q <= S_R;
          end
        end
        S_R: begin
          if (ifu_rvalid) begin
            if (drop_q || BRANCH_flushIF) begin
              drop_q  <= 1'b0;
              state_q <= S_AR;
            end else begin
              inst_q  <= ifu_rdata;
              state_q <= S_HOLD;
            end
          end else if (BRANCH_flushIF) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (BRANCH_flushIF || !FORWARD_stallIF) begin
            state_q <= S_AR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hold_valid  = (state_q == S_HOLD);
  assign ifu_arvalid = (state_q == S_AR);
  assign ifu_rready  = (state_q == S_R);
  assign ifu_araddr  = ar_addr_q;

  // The only combinational path to the IFU->IDU outputs: a redirect kills the
  // held instruction in the same cycle so decode never latches a wrong-path op.
  assign IFU_o_commit = hold_valid & ~BRANCH_flushIF;
  assign IFU_o_inst   = IFU_o_commit ? inst_q : NOP;
  assign IFU_o_pc     = pc_q;

`ifdef YSYX_23060136_IFU_PERF_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] wait_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 64'd0;
      wait_cnt_q  <= 64'd0;
    end else begin
      if (hold_valid && !BRANCH_flushIF && !FORWARD_stallIF) begin
        fetch_cnt_q <= fetch_cnt_q + 64'd1;
      end
      if (state_q == S_AR || state_q == S_R) begin
        wait_cnt_q <= wait_cnt_q + 64'd1;
      end
    end
  end

  assign IFU_o_fetch_cnt = fetch_cnt_q;
  assign IFU_o_wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060136_ifu_fetch
//   Memory responder with configurable arready / read latency, a transaction
//   level reference model checked every cycle, and directed scenarios with
//   literal expectations. Memory word at address a is a ^ 32'hDEAD_BEEF.
// ----------------------------------------------------------------------------
module tb_ysyx_23060136_ifu_fetch;

  localparam logic [31:0] PC_RST = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        commit;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        rready;
`ifdef YSYX_23060136_IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory behaviour knobs: ar_mode 0=always ready, 1=never, 2=random.
  // rd_delay: cycles between acceptance and data; -1 = random 0..3.
  int ar_mode  = 0;
  int rd_delay = 0;

  always #5 clk = ~clk;

  ysyx_23060136_ifu_fetch dut (
    .clk             (clk),
    .rst             (rst_n),
    .BRANCH_flushIF  (flush),
    .BRANCH_target   (br_target),
    .FORWARD_stallIF (stall),
    .IFU_o_pc        (pc),
    .IFU_o_inst      (inst),
    .IFU_o_commit    (commit),
    .ifu_arvalid     (arvalid),
    .ifu_araddr      (araddr),
    .ifu_arready     (arready),
    .ifu_rvalid      (rvalid),
    .ifu_rdata       (rdata),
    .ifu_rready      (rready)
`ifdef YSYX_23060136_IFU_PERF_EN
    ,
    .IFU_o_fetch_cnt (fetch_cnt),
    .IFU_o_wait_cnt  (wait_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : memory
    bit          ar_hs, r_hs, busy;
    logic [31:0] hs_addr, pend;
    int          wcnt;
    busy = 0; pend = '0; wcnt = 0;
    forever begin
      @(negedge clk);
      ar_hs   = rst_n && arvalid && arready;
      hs_addr = araddr;
      r_hs    = rst_n && rvalid && rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy   = 0;
        rvalid = 1'b0;
      end else begin
        if (r_hs) begin
          rvalid = 1'b0;
          busy   = 0;
        end
        if (ar_hs) begin
          busy = 1;
          pend = hs_addr;
          wcnt = (rd_delay < 0) ? int'($urandom_range(0, 3)) : rd_delay;
        end
        if (busy && !rvalid) begin
          if (wcnt == 0) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend);
          end else begin
            wcnt--;
          end
        end
      end
      if (!rvalid) rdata = $urandom;
      case (ar_mode)
        0:       arready = 1'b1;
        1:       arready = 1'b0;
        default: arready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // The model tracks the fetch at transaction level: a request waiting for
  // acceptance, a read waiting for data, a held instruction, and whether the
  // in-flight read was overtaken by a redirect.
  bit          m_start, m_req, m_rd, m_held, m_stale;
  logic [31:0] m_pc, m_addr;

  initial begin : compare
    logic [31:0] tgt;
    bit          exp_commit;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_commit", commit, 0);
        chk("rst_pc", pc, PC_RST);
        chk("rst_inst", inst, NOP);
        m_start = 1; m_req = 0; m_rd = 0; m_held = 0; m_stale = 0;
        m_pc = PC_RST; m_addr = PC_RST;
      end else begin
        exp_commit = m_held && !flush;
        chk("arvalid", arvalid, m_req);
        chk("rready", rready, m_rd);
        chk("commit", commit, exp_commit);
        chk("pc", pc, m_pc);
        chk("inst", inst, exp_commit ? mem_word(m_pc) : NOP);
        if (m_req) chk("araddr", araddr, m_addr);
        if (exp_commit && !stall)
          $display("[%0t] commit pc=%08h inst=%08h", $time, pc, inst);
        tgt = br_target & 32'hFFFF_FFFC;
        if (m_start) begin
          m_start = 0;
          if (flush) m_pc = tgt;
          m_req  = 1;
          m_addr = m_pc;
        end else if (m_req) begin
          if (flush) begin m_pc = tgt; m_stale = 1; end
          if (arready) begin m_req = 0; m_rd = 1; end
        end else if (m_rd) begin
          if (flush) m_pc = tgt;
          if (rvalid) begin
            m_rd = 0;
            if (m_stale || flush) begin
              m_stale = 0; m_req = 1; m_addr = m_pc;
            end else begin
              m_held = 1;
            end
          end else if (flush) begin
            m_stale = 1;
          end
        end else if (m_held) begin
          if (flush) begin
            m_held = 0; m_pc = tgt; m_req = 1; m_addr = tgt;
          end else if (!stall) begin
            m_held = 0; m_pc = m_pc + 32'd4; m_req = 1; m_addr = m_pc;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Returns at the negedge where the selected output is high (0=arvalid,
  // 1=rready, 2=commit); a timeout counts as a failed comparison.
  task automatic wait_neg(input int sel, input string name);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = arvalid;
        1:       hit = rready;
        default: hit = commit;
      endcase
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: timeout waiting, got 0 required 1", name);
    end
  endtask

  task automatic pulse_flush(input logic [31:0] t);
    @(posedge clk); #1;
    flush = 1'b1; br_target = t;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int          first_ar, ncom;
    int          com_cyc [4];
    logic [31:0] com_pc [4];
    logic [31:0] com_inst [4];
    logic [31:0] ar0, held_pc, held_inst, a_old;
    bit          prev_ar, got_ar;

    // 1: back-to-back fetch, arready always high, data one cycle later
    ar_mode = 0; rd_delay = 0;
    do_reset();
    first_ar = -1; ncom = 0; ar0 = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (arvalid && first_ar < 0) begin first_ar = c; ar0 = araddr; end
      if (commit && ncom < 4) begin
        com_cyc[ncom] = c; com_pc[ncom] = pc; com_inst[ncom] = inst; ncom++;
      end
    end
    chk("t1_first_ar_cycle", first_ar, 1);
    chk("t1_first_araddr", ar0, 32'h8000_0000);
    chk("t1_commit_count", ncom, 3);
    chk("t1_c0_cycle", com_cyc[0], 3);
    chk("t1_c0_pc", com_pc[0], 32'h8000_0000);
    chk("t1_c0_inst", com_inst[0], 32'h5EAD_BEEF);
    chk("t1_c1_cycle", com_cyc[1], 6);
    chk("t1_c1_pc", com_pc[1], 32'h8000_0004);
    chk("t1_c1_inst", com_inst[1], 32'h5EAD_BEEB);

    // 2: stall held five cycles in the hold state
    do_reset();
    stall = 1'b1;
    wait_neg(2, "t2_commit");
    held_pc = pc; held_inst = inst;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_stall_commit", commit, 1);
      chk("t2_stall_pc", pc, held_pc);
      chk("t2_stall_inst", inst, held_inst);
      chk("t2_stall_arvalid", arvalid, 0);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    chk("t2_release_commit", commit, 1);
    @(negedge clk);
    chk("t2_adv_arvalid", arvalid, 1);
    chk("t2_adv_araddr", araddr, held_pc + 32'd4);
    chk("t2_adv_commit", commit, 0);

    // 3: redirect while waiting for data, data arrives two cycles later
    rd_delay = 3;
    do_reset();
    wait_neg(1, "t3_rready");
    pulse_flush(32'h8000_1000);
    got_ar = 0; ar0 = '0; held_pc = '0; held_inst = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arvalid && !got_ar) begin got_ar = 1; ar0 = araddr; end
      if (commit) begin held_pc = pc; held_inst = inst; break; end
    end
    chk("t3_next_araddr", ar0, 32'h8000_1000);
    chk("t3_commit_pc", held_pc, 32'h8000_1000);
    chk("t3_commit_inst", held_inst, 32'h5EAD_AEEF);

    // 4: redirect in the same cycle the data arrives
    rd_delay = 1;
    do_reset();
    wait_neg(1, "t4_rready");
    @(posedge clk); #1;
    flush = 1'b1; br_target = 32'h8000_2000;
    @(negedge clk);
    chk("t4_rvalid_cycle_commit", commit, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t4_commit_after", commit, 0);
    chk("t4_arvalid", arvalid, 1);
    chk("t4_araddr", araddr, 32'h8000_2000);
    wait_neg(2, "t4_commit");
    chk("t4_commit_pc", pc, 32'h8000_2000);
    chk("t4_commit_inst", inst, 32'h5EAD_9EEF);

    // 5: arready low four cycles, redirect in the second of them
    ar_mode = 1; rd_delay = 0;
    do_reset();
    wait_neg(0, "t5_arvalid");
    a_old = araddr;
    @(posedge clk); #1;
    flush = 1'b1; br_target = 32'h8000_3000;
    @(negedge clk);
    chk("t5_c2_araddr", araddr, a_old);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t5_c3_araddr", araddr, a_old);
    @(negedge clk);
    chk("t5_c4_araddr", araddr, a_old);
    chk("t5_c4_arvalid", arvalid, 1);
    ar_mode = 0;
    prev_ar = 1; got_ar = 0; ar0 = '0; held_pc = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (arvalid && !prev_ar && !got_ar) begin got_ar = 1; ar0 = araddr; end
      prev_ar = arvalid;
      if (commit) begin held_pc = pc; break; end
    end
    chk("t5_refetch_araddr", ar0, 32'h8000_3000);
    chk("t5_commit_pc", held_pc, 32'h8000_3000);

    // 6: asynchronous reset while waiting for data
    rd_delay = 3;
    do_reset();
    wait_neg(2, "t6_first_commit");
    wait_neg(1, "t6_rready");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_arvalid", arvalid, 0);
    chk("t6_async_rready", rready, 0);
    chk("t6_async_commit", commit, 0);
    chk("t6_async_pc", pc, 32'h8000_0000);
    chk("t6_async_inst", inst, 32'h0000_0013);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_neg(0, "t6_arvalid");
    chk("t6_restart_araddr", araddr, 32'h8000_0000);
    wait_neg(2, "t6_commit");
    chk("t6_restart_pc", pc, 32'h8000_0000);
    chk("t6_restart_inst", inst, 32'h5EAD_BEEF);

    // 7: unaligned redirect in the idle cycle, then PC wrap-around
    rd_delay = 0;
    do_reset();
    flush = 1'b1; br_target = 32'hFFFF_FFFF;
    @(posedge clk); #1 flush = 1'b0;
    wait_neg(2, "t7_commit0");
    chk("t7_c0_pc", pc, 32'hFFFF_FFFC);
    chk("t7_c0_inst", inst, 32'h2152_4113);
    @(negedge clk);
    wait_neg(2, "t7_commit1");
    chk("t7_c1_pc", pc, 32'h0000_0000);
    chk("t7_c1_inst", inst, 32'hDEAD_BEEF);

    // Random: arready, latency, stall and redirects all randomized
    ar_mode = 2; rd_delay = -1;
    do_reset();
    repeat (1500) begin
      @(posedge clk); #1;
      flush     = ($urandom_range(0, 99) < 8);
      br_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      stall     = ($urandom_range(0, 99) < 30);
    end
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
